// File: rtl/simon_playback_seq.sv
// Plays a stored Simon pattern from the pattern memory onto the LEDs, with timed hold and gap intervals.
// Optional build macro SIMON_PLAYBACK_ONEHOT_CHECK_EN: non-one-hot entries are shown as all-ones and set bad_entry_o.
module simon_playback_seq #(
    parameter int ADDR_W      = 6,
    parameter int DATA_W      = 4,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int CNT_W       = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W:0]   len_i,
    input  logic              abort_i,
    output logic [ADDR_W-1:0] r_addr_o,
    input  logic [DATA_W-1:0] r_data_i,
    output logic [DATA_W-1:0] pattern_leds_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              bad_entry_o
);

    // state | meaning
    // IDLE  | waiting for start, LEDs dark
    // FETCH | r_addr holds idx, memory data captured at the next edge
    // SHOW  | entry on LEDs for HOLD_CYCLES
    // GAP   | LEDs dark for GAP_CYCLES before the next entry
    // DONE  | one-cycle done pulse
    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHOW,
        GAP,
        DONE
    } state_t;

    localparam logic [ADDR_W:0]  IDX_ONE  = 1;
    localparam logic [CNT_W-1:0] TMR_ONE  = 1;
    localparam logic [CNT_W-1:0] HOLD_TOP = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_TOP  = CNT_W'(GAP_CYCLES - 1);

    state_t              state_q, state_d;
    logic [ADDR_W:0]     idx_q, idx_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [CNT_W-1:0]    timer_q, timer_d;
    logic [DATA_W-1:0]   leds_q, leds_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                bad_q, bad_d;
    logic [DATA_W-1:0]   load_val;
    logic                load_bad;

`ifdef SIMON_PLAYBACK_ONEHOT_CHECK_EN
    always_comb begin
        load_val = r_data_i;
        load_bad = 1'b0;
        if (!$onehot(r_data_i)) begin
            load_val = '1;
            load_bad = 1'b1;
        end
    end
`else
    always_comb begin
        load_val = r_data_i;
        load_bad = 1'b0;
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            timer_q <= '0;
            leds_q  <= '0;
            addr_q  <= '0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            timer_q <= timer_d;
            leds_q  <= leds_d;
            addr_q  <= addr_d;
            bad_q   <= bad_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        timer_d = timer_q;
        leds_d  = leds_q;
        addr_d  = addr_q;
        bad_d   = bad_q;

        if (abort_i && (state_q != IDLE)) begin
            state_d = IDLE;
            idx_d   = '0;
            timer_d = '0;
            leds_d  = '0;
            addr_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    leds_d = '0;
                    if (start_i) begin
                        bad_d = 1'b0;
                        if (len_i != '0) begin
                            len_d   = len_i;
                            idx_d   = '0;
                            addr_d  = '0;
                            state_d = FETCH;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                FETCH: begin
                    leds_d  = load_val;
                    bad_d   = bad_q | load_bad;
                    timer_d = HOLD_TOP;
                    state_d = SHOW;
                end
                SHOW: begin
                    if (timer_q == '0) begin
                        leds_d = '0;
                        if (idx_q == len_q - IDX_ONE) begin
                            state_d = DONE;
                        end else begin
                            timer_d = GAP_TOP;
                            state_d = GAP;
                        end
                    end else begin
                        timer_d = timer_q - TMR_ONE;
                    end
                end
                GAP: begin
                    leds_d = '0;
                    if (timer_q == '0) begin
                        idx_d   = idx_q + IDX_ONE;
                        addr_d  = idx_d[ADDR_W-1:0];
                        state_d = FETCH;
                    end else begin
                        timer_d = timer_q - TMR_ONE;
                    end
                end
                DONE: begin
                    leds_d  = '0;
                    state_d = IDLE;
                end
                default: begin
                    leds_d  = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign r_addr_o       = addr_q;
    assign pattern_leds_o = leds_q;
    assign busy_o         = (state_q != IDLE);
    assign done_o         = (state_q == DONE);
    assign bad_entry_o    = bad_q;

endmodule
